// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// funct3 size codes, byte-lane size masks and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            2'b10:   return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    // Unsupported size codes and accesses not naturally aligned to their size.
    function automatic logic req_illegal(input logic       store,
                                         input logic [2:0] f3,
                                         input logic [2:0] off);
        if (store && f3[2])
            return 1'b1;
        if (!store && (f3 == 3'b111))
            return 1'b1;
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment: shifts store data and mask into their
// lanes and extracts/extends load data from the addressed lanes.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      i_funct3,
    input  logic [2:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_wdata,
    output logic [7:0]      o_wmask,
    output logic [XLEN-1:0] o_ldata
);

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_rsh;

    assign w_shamt = {i_off, 3'b000};
    assign w_rsh   = i_rdata >> w_shamt;
    assign o_wdata = i_wdata << w_shamt;
    assign o_wmask = size_mask(i_funct3[1:0]) << i_off;

    always_comb begin
        o_ldata = w_rsh;
        case (i_funct3)
            F3_B:    o_ldata = {{(XLEN-8){w_rsh[7]}},   w_rsh[7:0]};
            F3_H:    o_ldata = {{(XLEN-16){w_rsh[15]}}, w_rsh[15:0]};
            F3_W:    o_ldata = {{(XLEN-32){w_rsh[31]}}, w_rsh[31:0]};
            F3_D:    o_ldata = w_rsh;
            F3_BU:   o_ldata = {{(XLEN-8){1'b0}},  w_rsh[7:0]};
            F3_HU:   o_ldata = {{(XLEN-16){1'b0}}, w_rsh[15:0]};
            F3_WU:   o_ldata = {{(XLEN-32){1'b0}}, w_rsh[31:0]};
            default: o_ldata = w_rsh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: IDLE accepts a request, ACCESS
// drives the data memory for one cycle, RESP holds the result until taken.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    output logic            dmem_en,
    output logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wmask,
    output logic            dmem_wen,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic [4:0]      out_rd,
    output logic            out_err
);

    lsu_state_e      r_state;
    lsu_state_e      w_state_nxt;
    logic            r_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic            r_err;
    logic [XLEN-1:0] r_rdata;

    logic            w_illegal;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_wmask;
    logic [XLEN-1:0] w_ldata;

    assign w_illegal = req_illegal(in_store, in_funct3, in_addr[2:0]);

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[2:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (dmem_rdata),
        .o_wdata  (w_wdata),
        .o_wmask  (w_wmask),
        .o_ldata  (w_ldata)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Enables are gated by rst so a reset landing on ACCESS never commits a write.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        dmem_en     = 1'b0;
        dmem_wen    = 1'b0;
        dmem_wmask  = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = w_illegal ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                dmem_en     = !r_store && !rst;
                dmem_wen    = r_store && !rst;
                dmem_wmask  = r_store ? w_wmask : 8'h00;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_store  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_store  <= in_store;
                r_funct3 <= in_funct3;
                r_addr   <= in_addr;
                r_wdata  <= in_wdata;
                r_rd     <= in_rd;
                r_err    <= w_illegal;
                r_rdata  <= '0;
            end
            if (r_state == ST_ACCESS && !r_store)
                r_rdata <= w_ldata;
        end
    end

    assign dmem_addr  = {r_addr[XLEN-1:3], 3'b000};
    assign dmem_wdata = w_wdata;
    assign out_rdata  = r_rdata;
    assign out_rd     = r_rd;
    assign out_err    = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-masked memory model and a response
// scoreboard filled at issue time and drained when out_valid is seen.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        dmem_en;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_rdata;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_wen;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int acc_first = 0;

    typedef struct packed {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } resp_t;

    resp_t sb[$];

    logic [63:0] mem [0:15];
    logic        mem_load;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_store   (in_store),
        .in_funct3  (in_funct3),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .in_rd      (in_rd),
        .dmem_en    (dmem_en),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_wdata (dmem_wdata),
        .dmem_wmask (dmem_wmask),
        .dmem_wen   (dmem_wen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_rd     (out_rd),
        .out_err    (out_err)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_load) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= 64'h0;
            mem[0] <= 64'h0000_0000_8F00_0000;
            mem[1] <= 64'h1111_1111_1111_1111;
        end else if (dmem_wen) begin
            for (int b = 0; b < 8; b++)
                if (dmem_wmask[b])
                    mem[dmem_addr[6:3]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
    end

    assign dmem_rdata = mem[dmem_addr[6:3]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rd,
                           input logic e_err, input logic [63:0] e_rdata,
                           input logic [7:0] e_mask, input logic [63:0] e_wdata, input int hold);
        resp_t r;
        r.rdata = e_rdata;
        r.rd    = rd;
        r.err   = e_err;
        sb.push_back(r);
        chk({tag, ".in_ready_idle"}, {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = a;
        in_wdata  = wd;
        in_rd     = rd;
        step();
        acc_cyc   = cyc;
        in_valid  = 1'b0;
        in_addr   = {$urandom, $urandom};
        in_wdata  = {$urandom, $urandom};
        in_funct3 = 3'($urandom_range(0, 7));
        in_store  = ~st;
        in_rd     = ~rd;
        out_ready = (hold == 0);
        if (!e_err) begin
            chk({tag, ".acc_en"},    {63'd0, dmem_en},  {63'd0, !st});
            chk({tag, ".acc_wen"},   {63'd0, dmem_wen}, {63'd0, st});
            chk({tag, ".acc_addr"},  dmem_addr, {a[63:3], 3'b000});
            chk({tag, ".acc_valid"}, {63'd0, out_valid}, 64'd0);
            chk({tag, ".acc_ready"}, {63'd0, in_ready}, 64'd0);
            if (st) begin
                chk({tag, ".acc_wmask"}, {56'd0, dmem_wmask}, {56'd0, e_mask});
                chk({tag, ".acc_wdata"}, dmem_wdata, e_wdata);
            end
            step();
        end
        chk({tag, ".resp_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, ".resp_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, ".resp_en"},    {62'd0, dmem_en, dmem_wen}, 64'd0);
        chk({tag, ".resp_wmask"}, {56'd0, dmem_wmask}, 64'd0);
        r = sb.pop_front();
        chk({tag, ".rdata"}, out_rdata, r.rdata);
        chk({tag, ".rd"},    {59'd0, out_rd}, {59'd0, r.rd});
        chk({tag, ".err"},   {63'd0, out_err}, {63'd0, r.err});
        for (int i = 1; i < hold; i++) begin
            step();
            chk({tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, ".hold_rdata"}, out_rdata, r.rdata);
            chk({tag, ".hold_ready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk({tag, ".done_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, ".done_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        mem_load  = 1'b1;
        in_valid  = 1'b0;
        in_store  = 1'b0;
        in_funct3 = 3'b000;
        in_addr   = 64'h0;
        in_wdata  = 64'h0;
        in_rd     = 5'd0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst.en_gated", {62'd0, dmem_en, dmem_wen}, 64'd0);
        mem_load = 1'b0;
        rst      = 1'b0;
        step();
        chk("rst.in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.out_rdata", out_rdata, 64'd0);
        chk("rst.out_rd",    {59'd0, out_rd}, 64'd0);
        chk("rst.out_err",   {63'd0, out_err}, 64'd0);
        chk("rst.wmask",     {56'd0, dmem_wmask}, 64'd0);

        run_req("lb",   1'b0, 3'b000, 64'h8000_0003, 64'h0, 5'd5, 1'b0,
                64'hFFFF_FFFF_FFFF_FF8F, 8'h00, 64'h0, 0);
        run_req("sh",   1'b1, 3'b001, 64'h8000_0006, 64'hABCD, 5'd3, 1'b0,
                64'h0, 8'hC0, 64'hABCD_0000_0000_0000, 0);
        run_req("lw_mis", 1'b0, 3'b010, 64'h8000_0002, 64'h0, 5'd9, 1'b1,
                64'h0, 8'h00, 64'h0, 0);
        run_req("lwu_hold", 1'b0, 3'b110, 64'h8000_0004, 64'h0, 5'd10, 1'b0,
                64'h0000_0000_ABCD_0000, 8'h00, 64'h0, 5);
        run_req("lw",   1'b0, 3'b010, 64'h8000_0004, 64'h0, 5'd11, 1'b0,
                64'hFFFF_FFFF_ABCD_0000, 8'h00, 64'h0, 0);
        run_req("lh",   1'b0, 3'b001, 64'h8000_0006, 64'h0, 5'd12, 1'b0,
                64'hFFFF_FFFF_FFFF_ABCD, 8'h00, 64'h0, 0);
        run_req("lhu",  1'b0, 3'b101, 64'h8000_0006, 64'h0, 5'd13, 1'b0,
                64'h0000_0000_0000_ABCD, 8'h00, 64'h0, 0);
        run_req("ld",   1'b0, 3'b011, 64'h8000_0000, 64'h0, 5'd14, 1'b0,
                64'hABCD_0000_8F00_0000, 8'h00, 64'h0, 0);
        run_req("ld_f7", 1'b0, 3'b111, 64'h8000_0000, 64'h0, 5'd15, 1'b1,
                64'h0, 8'h00, 64'h0, 0);
        run_req("st_f4", 1'b1, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 1'b1,
                64'h0, 8'h00, 64'h0, 0);
        run_req("sd_mis", 1'b1, 3'b011, 64'h8000_0004, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 1'b1,
                64'h0, 8'h00, 64'h0, 0);
        run_req("ld_after_err", 1'b0, 3'b011, 64'h8000_0000, 64'h0, 5'd18, 1'b0,
                64'hABCD_0000_8F00_0000, 8'h00, 64'h0, 0);

        run_req("sb",   1'b1, 3'b000, 64'h8000_0009, 64'hFFFF_FFFF_FFFF_FFA5, 5'd19, 1'b0,
                64'h0, 8'h02, 64'hFFFF_FFFF_FFFF_A500, 0);
        acc_first = acc_cyc;
        run_req("lbu",  1'b0, 3'b100, 64'h8000_0009, 64'h0, 5'd20, 1'b0,
                64'h0000_0000_0000_00A5, 8'h00, 64'h0, 0);
        chk("b2b.interval", 64'(acc_cyc - acc_first), 64'd3);
        run_req("lb_sext", 1'b0, 3'b000, 64'h8000_0009, 64'h0, 5'd21, 1'b0,
                64'hFFFF_FFFF_FFFF_FFA5, 8'h00, 64'h0, 0);

        // Reset landing on the ACCESS cycle of a doubleword store.
        chk("rst_acc.in_ready", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_store  = 1'b1;
        in_funct3 = 3'b011;
        in_addr   = 64'h8000_0010;
        in_wdata  = 64'hDEAD_BEEF_0000_0001;
        in_rd     = 5'd7;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_acc.wen", {63'd0, dmem_wen}, 64'd0);
        chk("rst_acc.en",  {63'd0, dmem_en},  64'd0);
        step();
        rst = 1'b0;
        chk("rst_acc.in_ready_after", {63'd0, in_ready}, 64'd1);
        chk("rst_acc.out_valid",      {63'd0, out_valid}, 64'd0);
        chk("rst_acc.out_rd",         {59'd0, out_rd}, 64'd0);
        chk("rst_acc.out_rdata",      out_rdata, 64'd0);
        step();
        chk("rst_acc.no_resp", {63'd0, out_valid}, 64'd0);
        run_req("ld_no_commit", 1'b0, 3'b011, 64'h8000_0010, 64'h0, 5'd8, 1'b0,
                64'h0, 8'h00, 64'h0, 0);

        // Reset while an errored response is waiting on out_ready.
        in_valid  = 1'b1;
        in_store  = 1'b0;
        in_funct3 = 3'b111;
        in_addr   = 64'h8000_0000;
        in_rd     = 5'd12;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("rst_resp.err_before",   {63'd0, out_err}, 64'd1);
        chk("rst_resp.valid_before", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_resp.valid", {63'd0, out_valid}, 64'd0);
        chk("rst_resp.err",   {63'd0, out_err}, 64'd0);
        chk("rst_resp.rd",    {59'd0, out_rd}, 64'd0);
        chk("rst_resp.ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("sb.empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
